// File: rtl/prim_clock_switch_ctrl_if.sv
// Handshake and gate bundle for prim_clock_switch_ctrl.
// master: requester plus gate bank; slave: the controller.
interface prim_clock_switch_ctrl_if #(
  parameter int NumClk = 4,
  parameter int SelW   = $clog2(NumClk)
);
  logic              req_i;
  logic [SelW-1:0]   sel_i;
  logic [NumClk-1:0] gate_status_i;
  logic [NumClk-1:0] gate_en_o;
  logic [SelW-1:0]   cur_sel_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output req_i, sel_i, gate_status_i,
    input  gate_en_o, cur_sel_o, busy_o, done_o, err_o
  );

  modport slave (
    input  req_i, sel_i, gate_status_i,
    output gate_en_o, cur_sel_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/prim_clock_switch_ctrl.sv
// Break-before-make sequencer for an N-input glitch-free clock switch.
// Optional gate-status watchdog: define PRIM_CLOCK_SWITCH_TIMEOUT_EN.
module prim_clock_switch_ctrl #(
  parameter int NumClk        = 4,
  parameter int SelW          = $clog2(NumClk),
  parameter int ResetSel      = 0,
  parameter int DeadCycles    = 4,
  parameter int TimeoutCycles = 64
) (
  input logic clk_i,
  input logic rst_i,
  prim_clock_switch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DEAD,
    ENABLE
  } state_e;

  localparam logic [NumClk-1:0] OneHot = NumClk'(1);
  localparam logic [NumClk-1:0] RstEn  = OneHot << ResetSel;
  localparam logic [SelW-1:0]   RstSel = SelW'(ResetSel);

  state_e            state_q, state_d;
  logic [SelW-1:0]   cur_q, cur_d;
  logic [SelW-1:0]   tgt_q, tgt_d;
  logic [NumClk-1:0] gate_q, gate_d;
  logic [7:0]        dead_q, dead_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              dead_last;

  assign dead_last = int'(dead_q) + 1 >= DeadCycles;

`ifdef PRIM_CLOCK_SWITCH_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic        wait_last;

  assign wait_last = int'(wait_q) + 1 >= TimeoutCycles;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    gate_d  = gate_q;
    dead_d  = dead_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (int'(bus.sel_i) >= NumClk) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (bus.sel_i == cur_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = bus.sel_i;
            err_d   = 1'b0;
            gate_d  = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!bus.gate_status_i[cur_q]) begin
          dead_d  = '0;
          state_d = DEAD;
        end
      end
      DEAD: begin
        if (dead_last) begin
          gate_d  = OneHot << tgt_q;
          state_d = ENABLE;
        end else if (dead_q != '1) begin
          dead_d = dead_q + 8'd1;
        end
      end
      ENABLE: begin
        if (bus.gate_status_i[tgt_q]) begin
          cur_d   = tgt_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PRIM_CLOCK_SWITCH_TIMEOUT_EN
    wait_d = '0;
    if ((state_q == DRAIN || state_q == ENABLE) &&
        state_d == state_q) begin
      if (wait_last) begin
        // Give up and fall back to the always-safe reset channel
        err_d   = 1'b1;
        done_d  = 1'b1;
        gate_d  = RstEn;
        cur_d   = RstSel;
        state_d = IDLE;
      end else if (wait_q != '1) begin
        wait_d = wait_q + 16'd1;
      end
    end
`else
    // DRAIN and ENABLE wait for gate status without limit
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cur_q   <= RstSel;
      tgt_q   <= RstSel;
      gate_q  <= RstEn;
      dead_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      gate_q  <= gate_d;
      dead_q  <= dead_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.gate_en_o = gate_q;
  assign bus.cur_sel_o = cur_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_prim_clock_switch_ctrl.sv
// Directed bench for prim_clock_switch_ctrl: latency, reject,
// watchdog, reset-mid-switch and one-hot stress.
module tb_prim_clock_switch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  prim_clock_switch_ctrl_if #(.NumClk(4)) bus_a ();
  prim_clock_switch_ctrl_if #(.NumClk(3)) bus_b ();

  logic       follow_a = 1'b1;
  logic [3:0] stat_a   = '0;

  assign bus_a.gate_status_i = follow_a ? bus_a.gate_en_o : stat_a;
  assign bus_b.gate_status_i = bus_b.gate_en_o;

  prim_clock_switch_ctrl #(
    .NumClk(4), .ResetSel(0), .DeadCycles(4), .TimeoutCycles(64)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a)
  );

  prim_clock_switch_ctrl #(
    .NumClk(3), .ResetSel(0), .DeadCycles(0), .TimeoutCycles(64)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_a(input logic [1:0] s, input int bound,
                       output int done_at, output int zeros,
                       output logic busy0);
    @(negedge clk);
    bus_a.req_i = 1'b1;
    bus_a.sel_i = s;
    done_at = -1;
    zeros   = 0;
    busy0   = 1'b0;
    for (int i = 0; i <= bound; i++) begin
      @(negedge clk);
      bus_a.req_i = 1'b0;
      if (i == 0) busy0 = bus_a.busy_o;
      if (bus_a.gate_en_o == '0) zeros++;
      if (bus_a.done_o) begin
        done_at = i;
        break;
      end
    end
  endtask

  task automatic run_b(input logic [1:0] s, input int bound,
                       output int done_at, output logic err0,
                       output logic busy0);
    @(negedge clk);
    bus_b.req_i = 1'b1;
    bus_b.sel_i = s;
    done_at = -1;
    err0    = 1'b0;
    busy0   = 1'b0;
    for (int i = 0; i <= bound; i++) begin
      @(negedge clk);
      bus_b.req_i = 1'b0;
      if (i == 0) begin
        busy0 = bus_b.busy_o;
        err0  = bus_b.err_o;
      end
      if (bus_b.done_o) begin
        done_at = i;
        break;
      end
    end
  endtask

  int   d_at;
  int   zeros;
  logic b0;
  logic e0;
  int   viol;
  int   seen;

  initial begin
    bus_a.req_i = 1'b0;
    bus_a.sel_i = '0;
    bus_b.req_i = 1'b0;
    bus_b.sel_i = '0;

    #12;
    chk("rst_hold_gate", 32'(bus_a.gate_en_o), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gate", 32'(bus_a.gate_en_o), 32'h1);
    chk("rst_cur", 32'(bus_a.cur_sel_o), 32'h0);
    chk("rst_busy", 32'(bus_a.busy_o), 32'h0);
    chk("rst_done", 32'(bus_a.done_o), 32'h0);
    chk("rst_err", 32'(bus_a.err_o), 32'h0);
    chk("rst_gate_b", 32'(bus_b.gate_en_o), 32'h1);

    // switch 0 -> 2: DRAIN 1, DEAD 4, ENABLE 1
    run_a(2'd2, 20, d_at, zeros, b0);
    chk("sw2_busy0", 32'(b0), 32'h1);
    chk("sw2_done_at", 32'(d_at), 32'd6);
    chk("sw2_zero_cyc", 32'(zeros), 32'd5);
    chk("sw2_gate", 32'(bus_a.gate_en_o), 32'h4);
    chk("sw2_cur", 32'(bus_a.cur_sel_o), 32'h2);
    chk("sw2_busy_end", 32'(bus_a.busy_o), 32'h0);
    chk("sw2_err", 32'(bus_a.err_o), 32'h0);
    @(negedge clk);
    chk("sw2_done_pulse", 32'(bus_a.done_o), 32'h0);

    // same channel request
    run_a(2'd2, 5, d_at, zeros, b0);
    chk("same_done_at", 32'(d_at), 32'd0);
    chk("same_busy", 32'(b0), 32'h0);
    chk("same_gate", 32'(bus_a.gate_en_o), 32'h4);

    // out-of-range on 3-channel instance
    run_b(2'd3, 5, d_at, e0, b0);
    chk("oor_done_at", 32'(d_at), 32'd0);
    chk("oor_err", 32'(bus_b.err_o), 32'h1);
    chk("oor_busy", 32'(b0), 32'h0);
    chk("oor_gate", 32'(bus_b.gate_en_o), 32'h1);
    @(negedge clk);
    chk("oor_err_sticky", 32'(bus_b.err_o), 32'h1);
    chk("oor_done_pulse", 32'(bus_b.done_o), 32'h0);

    // DeadCycles=0 switch clears err, DEAD is one cycle
    run_b(2'd2, 10, d_at, e0, b0);
    chk("d0_err_clr", 32'(e0), 32'h0);
    chk("d0_busy0", 32'(b0), 32'h1);
    chk("d0_done_at", 32'(d_at), 32'd3);
    chk("d0_gate", 32'(bus_b.gate_en_o), 32'h4);
    chk("d0_cur", 32'(bus_b.cur_sel_o), 32'h2);

    // old gate status stuck on during switch 2 -> 1
    follow_a = 1'b0;
    stat_a   = 4'b0100;
    run_a(2'd1, 100, d_at, zeros, b0);
`ifdef PRIM_CLOCK_SWITCH_TIMEOUT_EN
    chk("to_done_at", 32'(d_at), 32'd64);
    chk("to_err", 32'(bus_a.err_o), 32'h1);
    chk("to_gate", 32'(bus_a.gate_en_o), 32'h1);
    chk("to_cur", 32'(bus_a.cur_sel_o), 32'h0);
    follow_a = 1'b1;
    @(negedge clk);
`else
    chk("stuck_no_done", 32'(d_at), 32'hffffffff);
    chk("stuck_busy", 32'(bus_a.busy_o), 32'h1);
    chk("stuck_gate", 32'(bus_a.gate_en_o), 32'h0);
    chk("stuck_cur", 32'(bus_a.cur_sel_o), 32'h2);
    follow_a = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.done_o) begin
        seen = 1;
        break;
      end
    end
    chk("stuck_recover", 32'(seen), 32'h1);
    chk("stuck_rec_cur", 32'(bus_a.cur_sel_o), 32'h1);
    chk("stuck_rec_gate", 32'(bus_a.gate_en_o), 32'h2);
`endif

    // reset asserted while in DEAD
    @(negedge clk);
    bus_a.req_i = 1'b1;
    bus_a.sel_i = 2'd3;
    @(negedge clk);
    bus_a.req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dead_gate", 32'(bus_a.gate_en_o), 32'h0);
    chk("dead_busy", 32'(bus_a.busy_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_gate", 32'(bus_a.gate_en_o), 32'h1);
    chk("arst_busy", 32'(bus_a.busy_o), 32'h0);
    chk("arst_cur", 32'(bus_a.cur_sel_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_rel_gate", 32'(bus_a.gate_en_o), 32'h1);

    // random request/status stress
    viol = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($countones(bus_a.gate_en_o) > 1) viol++;
      bus_a.req_i = ($urandom_range(0, 3) == 0);
      bus_a.sel_i = 2'($urandom_range(0, 3));
      follow_a    = ($urandom_range(0, 3) != 0);
      stat_a      = 4'($urandom_range(0, 15));
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1 if ($countones(bus_a.gate_en_o) > 1) viol++;
      end
      if (i == 1503) rst = 1'b0;
    end
    chk("onehot_stress", 32'(viol), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/prim_clock_switch_ctrl.md
# prim_clock_switch_ctrl

Parametrised break-before-make controller for an N-input glitch-free clock switch. It runs on a single always-on reference clock and sequences the one-hot enables of per-source clock gates. Switching is strictly ordered: old gate off, confirmed off, dead time, new gate on, confirmed on. It sits beside a bank of clock gates and an OR tree, replacing the plain two-input logic clock mux wherever a selector may change while the clocks are running.

## Interface
Parameters:
- NumClk, 4: number of clock sources; must be 2 to 16.
- SelW, $clog2(NumClk): width of the selector (derived).
- ResetSel, 0: channel that is enabled out of reset.
- DeadCycles, 4: idle reference cycles between old-off confirmation and new-on; must be 0 to 255.
- TimeoutCycles, 64: maximum wait for any gate-status confirmation; must be 1 to 65535.

Ports:
- clk_i  in  1  reference clock, always running.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  1  switch request, sampled in IDLE only.
- sel_i  in  SelW  requested channel, sampled with req_i.
- gate_status_i  in  NumClk  per-channel gate-active indication, already synchronised to clk_i.
- gate_en_o  out  NumClk  gate enables, at most one bit set.
- cur_sel_o  out  SelW  currently committed channel.
- busy_o  out  1  switch in progress.
- done_o  out  1  one-cycle pulse when a switch completes or is rejected.
- err_o  out  1  sticky error, cleared by the next accepted request or by reset.

## Operation
- Reset values:
  - gate_en_o = one-hot(ResetSel), asserted asynchronously.
  - cur_sel_o = ResetSel.
  - busy_o = 0, done_o = 0, err_o = 0.
  - FSM = IDLE; all counters 0.
- States:
  - IDLE: on req_i = 1, act on the sampled sel_i:
    - sel_i >= NumClk: no switch; pulse done_o, set err_o.
    - sel_i == cur_sel_o: no switch; pulse done_o, err_o unchanged.
    - Otherwise: latch target, clear err_o, drop gate_en_o[cur] the same edge, go to DRAIN.
  - DRAIN: gate_en_o is all zero. When gate_status_i[cur] == 0, load the dead counter and go to DEAD.
  - DEAD: count DeadCycles cycles. At terminal count set gate_en_o[target] = 1 and go to ENABLE. With DeadCycles = 0, DEAD lasts exactly one cycle.
  - ENABLE: when gate_status_i[target] == 1, update cur_sel_o to the target, pulse done_o, go to IDLE.
- busy_o = 1 in DRAIN, DEAD and ENABLE.
- req_i is ignored outside IDLE. There is no queueing; the requester must wait for done_o.
- Status bits of non-involved channels are ignored.
- Counters saturate and never wrap.
- No state of gate_en_o ever has more than one bit set, including during reset assertion and release.

## Timing
- Output latencies from the edge sampling an accepted req_i:
  - Old enable falls at edge 0, registered.
  - busy_o rises at edge 0.
- Minimum switch time with immediate status response is 1 (DRAIN) + max(DeadCycles,1) (DEAD) + 1 (ENABLE) cycles. For DeadCycles = 4, done_o pulses 6 cycles after acceptance.
- A rejected or same-channel request pulses done_o on the cycle after acceptance, with busy_o staying 0.
- cur_sel_o and done_o change on the same edge.
- Reset asserted mid-switch immediately forces the reset values, including re-enabling ResetSel. The integrator guarantees that reset is asserted only while clocks are quiescent.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- PRIM_CLOCK_SWITCH_TIMEOUT_EN defined:
  - A 16-bit wait counter runs in DRAIN and ENABLE and is cleared on each state entry.
  - Reaching TimeoutCycles without the expected status aborts the switch: set err_o, pulse done_o, drive gate_en_o = one-hot(ResetSel), set cur_sel_o = ResetSel, return to IDLE.
- PRIM_CLOCK_SWITCH_TIMEOUT_EN undefined:
  - No counter is built; DRAIN and ENABLE wait indefinitely.
  - err_o is set only by out-of-range selectors.

## Test plan
- Reset release with NumClk = 4, ResetSel = 0 -> gate_en_o = 4'b0001, cur_sel_o = 0, busy_o = 0.
- req_i with sel_i = 2, status follows enables after 1 cycle, DeadCycles = 4 -> gate_en_o goes 0001, 0000 (5 cycles), 0100; done_o pulses 7 cycles after the request; cur_sel_o = 2.
- req_i with sel_i = 0 while cur_sel_o = 0 -> done_o pulses next cycle, busy_o stays 0, gate_en_o unchanged. With NumClk = 3, sel_i = 3 -> done_o pulses and err_o = 1.
- Hold gate_status_i[0] = 1 during a switch to channel 1 with the timeout macro defined and TimeoutCycles = 64 -> after 64 DRAIN cycles: err_o = 1, done_o pulses, gate_en_o = 0001. Without the macro, the FSM stays in DRAIN.
- Assert rst_i during DEAD -> gate_en_o = 0001 asynchronously and busy_o = 0. A random request/status stress run must never show more than one gate_en_o bit set.
